barker_sync_ctrl: RTL and testbench

- Chip-rate acquisition and tracking controller for the 11-chip Barker correlator (pattern 11100010010; its valid output is used here as corr_hit).
- Assembles the sliding chip window and drives it, with the threshold, to the shared correlator.
- Acquires symbol sync, then tests each symbol boundary for the true pattern and, if needed, for the inverted pattern, to demodulate one data bit per symbol.
- Declares loss of lock after repeated misses.

---
 rtl/barker_sync_ctrl.sv | 157 +++++++++++++++
 tb/tb_barker_sync_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barker_sync_ctrl.sv
// Barker-11 symbol sync controller: acquisition, polarity
// demodulation and loss-of-lock tracking around a shared correlator.
module barker_sync_ctrl #(
  parameter int MAX_MISS = 3,
  parameter int MISS_W   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        chip_in,
  input  logic        chip_valid,
  input  logic [3:0]  acq_thr,
  input  logic [3:0]  trk_thr,
  input  logic        corr_hit,
  output logic [10:0] din_buc,
  output logic [3:0]  threshold,
  output logic        locked,
  output logic        sync_pulse,
  output logic        bit_valid,
  output logic        bit_data,
  output logic        bit_err,
  output logic        lost_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCK,
    CHKINV
  } state_t;

  localparam logic [MISS_W-1:0] LAST_MISS = MISS_W'(MAX_MISS - 1);

  state_t            state;
  state_t            state_n;
  logic [10:0]       win;
  logic [10:0]       snap;
  logic [10:0]       snap_n;
  logic [3:0]        chip_cnt;
  logic [3:0]        chip_cnt_n;
  logic [MISS_W-1:0] miss_cnt;
  logic [MISS_W-1:0] miss_cnt_n;
  logic              eval;
  logic              sync_n;
  logic              bv_n;
  logic              bd_n;
  logic              be_n;
  logic              lost_n;

  assign din_buc   = (state == CHKINV) ? ~snap : win;
  assign threshold = (state == IDLE || state == SEARCH) ? acq_thr : trk_thr;
  assign locked    = (state == LOCK || state == CHKINV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      win        <= '0;
      snap       <= '0;
      chip_cnt   <= '0;
      miss_cnt   <= '0;
      eval       <= 1'b0;
      sync_pulse <= 1'b0;
      bit_valid  <= 1'b0;
      bit_data   <= 1'b0;
      bit_err    <= 1'b0;
      lost_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      snap       <= snap_n;
      chip_cnt   <= chip_cnt_n;
      miss_cnt   <= miss_cnt_n;
      sync_pulse <= sync_n;
      bit_valid  <= bv_n;
      bit_data   <= bd_n;
      bit_err    <= be_n;
      lost_pulse <= lost_n;
      // IDLE holds the window empty so every acquisition starts clean
      if (state == IDLE) begin
        win <= '0;
      end else if (chip_valid) begin
        win <= {win[9:0], chip_in};
      end
      eval <= chip_valid && (state != IDLE);
    end
  end

  always_comb begin
    state_n    = state;
    snap_n     = snap;
    chip_cnt_n = chip_cnt;
    miss_cnt_n = miss_cnt;
    sync_n     = 1'b0;
    bv_n       = 1'b0;
    bd_n       = bit_data;
    be_n       = bit_err;
    lost_n     = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = SEARCH;
        end
        SEARCH: begin
          if (eval && corr_hit) begin
            state_n    = LOCK;
            chip_cnt_n = '0;
            miss_cnt_n = '0;
            sync_n     = 1'b1;
          end
        end
        LOCK: begin
          if (eval) begin
            if (chip_cnt == 4'd10) begin
              chip_cnt_n = '0;
              if (corr_hit) begin
                bv_n       = 1'b1;
                bd_n       = 1'b1;
                be_n       = 1'b0;
                miss_cnt_n = '0;
              end else begin
                snap_n  = win;
                state_n = CHKINV;
              end
            end else begin
              chip_cnt_n = chip_cnt + 4'd1;
            end
          end
        end
        CHKINV: begin
          // a chip landing here belongs to the next symbol
          if (eval) begin
            chip_cnt_n = chip_cnt + 4'd1;
          end
          bv_n = 1'b1;
          bd_n = 1'b0;
          if (corr_hit) begin
            be_n       = 1'b0;
            miss_cnt_n = '0;
            state_n    = LOCK;
          end else begin
            be_n = 1'b1;
            if (miss_cnt == LAST_MISS) begin
              miss_cnt_n = '0;
              lost_n     = 1'b1;
              state_n    = SEARCH;
            end else begin
              miss_cnt_n = miss_cnt + 1'b1;
              state_n    = LOCK;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barker_sync_ctrl.sv
// Bench for barker_sync_ctrl: stub sum-rule correlator, event-scheduled
// expectation model and directed symbol sequences.
`timescale 1ns/1ps
module tb_barker_sync_ctrl;

  localparam int          MAXM = 3;
  localparam int          INF  = 1 << 30;
  localparam logic [10:0] PAT  = 11'b11100010010;
  localparam logic [10:0] NPAT = ~PAT;
  localparam logic [10:0] FLIP = PAT ^ 11'b00000100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        chip_in = 1'b0;
  logic        chip_valid = 1'b0;
  logic [3:0]  acq_thr = 4'd11;
  logic [3:0]  trk_thr = 4'd9;
  logic        corr_hit;
  logic [10:0] din_buc;
  logic [3:0]  threshold;
  logic        locked;
  logic        sync_pulse;
  logic        bit_valid;
  logic        bit_data;
  logic        bit_err;
  logic        lost_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barker_sync_ctrl #(.MAX_MISS(MAXM), .MISS_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .chip_in(chip_in), .chip_valid(chip_valid),
    .acq_thr(acq_thr), .trk_thr(trk_thr), .corr_hit(corr_hit),
    .din_buc(din_buc), .threshold(threshold), .locked(locked),
    .sync_pulse(sync_pulse), .bit_valid(bit_valid),
    .bit_data(bit_data), .bit_err(bit_err), .lost_pulse(lost_pulse)
  );

  function automatic int score(input logic [10:0] w);
    return $countones(~(w ^ PAT));
  endfunction

  assign corr_hit = (score(din_buc) >= int'(threshold));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: expectations keyed by cycle number
  int          cyc = 0;
  logic        m_on = 1'b0;
  logic        m_lock = 1'b0;
  logic [10:0] mwin = '0;
  int          sym_n = 0;
  int          misses = 0;
  int          search_from = 0;
  int          lock_on = INF;
  int          lock_off = 0;
  logic [1:0]  exp_bit [int];
  bit          exp_sync [int];
  bit          exp_lost [int];
  logic [10:0] exp_din [int];

  task automatic cancel_after(input int c);
    int ks[$];
    foreach (exp_bit[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) exp_bit.delete(ks[i]);
    ks.delete();
    foreach (exp_sync[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) exp_sync.delete(ks[i]);
    ks.delete();
    foreach (exp_lost[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) exp_lost.delete(ks[i]);
    ks.delete();
    foreach (exp_din[k]) if (k > c) ks.push_back(k);
    foreach (ks[i]) exp_din.delete(ks[i]);
  endtask

  always @(posedge clk) begin
    int e;
    e = cyc + 1;
    if (!rst_n || !en) begin
      cancel_after(cyc);
      m_on   = 1'b0;
      m_lock = 1'b0;
      if (lock_off > cyc + 1) lock_off = cyc + 1;
    end else if (!m_on) begin
      m_on        = 1'b1;
      m_lock      = 1'b0;
      mwin        = '0;
      search_from = 0;
      misses      = 0;
    end else if (chip_valid) begin
      mwin = {mwin[9:0], chip_in};
      if (!exp_din.exists(e)) exp_din[e] = mwin;
      if (!m_lock) begin
        if (e >= search_from && score(mwin) >= int'(acq_thr)) begin
          m_lock      = 1'b1;
          sym_n       = 0;
          misses      = 0;
          exp_sync[e + 1] = 1'b1;
          lock_on     = e + 1;
          lock_off    = INF;
        end
      end else begin
        sym_n++;
        if (sym_n == 11) begin
          sym_n = 0;
          if (score(mwin) >= int'(trk_thr)) begin
            exp_bit[e + 1] = 2'b10;
            misses = 0;
          end else begin
            exp_din[e + 1] = ~mwin;
            if (score(~mwin) >= int'(trk_thr)) begin
              exp_bit[e + 2] = 2'b00;
              misses = 0;
            end else begin
              exp_bit[e + 2] = 2'b01;
              misses++;
              if (misses == MAXM) begin
                misses      = 0;
                m_lock      = 1'b0;
                exp_lost[e + 2] = 1'b1;
                lock_off    = e + 2;
                search_from = e + 2;
              end
            end
          end
        end
      end
    end
    cyc++;
  end

  // Per-cycle compare plus event recording for the hand checks
  logic [10:0] prev_din = '0;
  logic [10:0] sync_din = '0;
  int          sync_cnt = 0;
  int          lost_cnt = 0;
  logic        q_bd[$];
  logic        q_be[$];
  logic [10:0] q_din[$];

  always @(negedge clk) begin
    logic el;
    if (cyc >= 1) begin
      el = (cyc >= lock_on) && (cyc < lock_off);
      check("sync_pulse", sync_pulse, int'(exp_sync.exists(cyc)));
      check("bit_valid", bit_valid, int'(exp_bit.exists(cyc)));
      check("lost_pulse", lost_pulse, int'(exp_lost.exists(cyc)));
      check("locked", locked, int'(el));
      check("threshold", threshold, el ? trk_thr : acq_thr);
      if (exp_bit.exists(cyc)) begin
        check("bit_data", bit_data, exp_bit[cyc][1]);
        check("bit_err", bit_err, exp_bit[cyc][0]);
      end
      if (exp_din.exists(cyc)) check("din_buc", din_buc, exp_din[cyc]);
      if (sync_pulse) begin
        sync_cnt++;
        sync_din = prev_din;
      end
      if (lost_pulse) lost_cnt++;
      if (bit_valid) begin
        q_bd.push_back(bit_data);
        q_be.push_back(bit_err);
        q_din.push_back(prev_din);
      end
    end
    prev_din = din_buc;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_chip(input logic b, input int gap);
    chip_in    = b;
    chip_valid = 1'b1;
    tick();
    chip_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_sym(input logic [10:0] s, input int gap);
    for (int i = 10; i >= 0; i--) send_chip(s[i], gap);
  endtask

  initial begin
    logic [10:0] s;
    tick();
    chip_valid = 1'b1;
    tick();
    chip_valid = 1'b0;
    tick();
    check("rst_sync", sync_pulse, 0);
    check("rst_bv", bit_valid, 0);
    check("rst_bd", bit_data, 0);
    check("rst_be", bit_err, 0);
    check("rst_lost", lost_pulse, 0);
    check("rst_locked", locked, 0);
    check("rst_din", din_buc, 0);
    check("rst_thr", threshold, 11);

    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) send_chip(1'b0, 3);
    send_sym(PAT, 3);
    repeat (2) tick();
    check("acq_sync_cnt", sync_cnt, 1);
    check("acq_din", sync_din, 11'b11100010010);
    check("acq_locked", locked, 1);
    check("acq_thr_trk", threshold, 9);

    send_sym(PAT, 3);
    send_sym(NPAT, 3);
    send_sym(FLIP, 3);
    repeat (3) tick();
    check("data_nbits", q_bd.size(), 3);
    if (q_bd.size() >= 3) begin
      check("data_b0", {q_bd[0], q_be[0]}, 2'b10);
      check("data_b1", {q_bd[1], q_be[1]}, 2'b00);
      check("data_b2", {q_bd[2], q_be[2]}, 2'b10);
      check("chkinv_din", q_din[1], 11'b11100010010);
    end

    repeat (3) send_sym(11'd0, 3);
    tick();
    check("loss_nbits", q_bd.size(), 6);
    if (q_bd.size() >= 6) begin
      for (int i = 3; i < 6; i++) check("loss_err", {q_bd[i], q_be[i]}, 2'b01);
    end
    check("loss_cnt", lost_cnt, 1);
    check("loss_locked", locked, 0);
    check("loss_thr", threshold, 11);

    send_sym(PAT, 1);
    send_sym(PAT, 1);
    send_sym(NPAT, 1);
    send_sym(FLIP, 1);
    send_sym(PAT, 1);
    repeat (3) tick();
    check("b2b_sync_cnt", sync_cnt, 2);
    check("b2b_nbits", q_bd.size(), 10);
    if (q_bd.size() >= 10) begin
      check("b2b_b0", {q_bd[6], q_be[6]}, 2'b10);
      check("b2b_b1", {q_bd[7], q_be[7]}, 2'b00);
      check("b2b_b2", {q_bd[8], q_be[8]}, 2'b10);
      check("b2b_b3", {q_bd[9], q_be[9]}, 2'b10);
    end

    s = NPAT;
    for (int i = 10; i >= 1; i--) send_chip(s[i], 3);
    chip_in    = s[0];
    chip_valid = 1'b1;
    tick();
    chip_valid = 1'b0;
    tick();
    check("chkinv_locked", locked, 1);
    en = 1'b0;
    tick();
    check("endrop_locked", locked, 0);
    check("endrop_bv", bit_valid, 0);
    en = 1'b1;
    tick();
    check("reen_din", din_buc, 0);
    check("reen_thr", threshold, 11);
    repeat (4) tick();
    check("endrop_nbits", q_bd.size(), 10);

    repeat (3) send_chip(1'b0, 3);
    send_sym(PAT, 3);
    repeat (2) tick();
    check("reacq_sync_cnt", sync_cnt, 3);
    check("reacq_din", sync_din, 11'b11100010010);
    check("reacq_locked", locked, 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
